// File: rtl/sss_demapper_if.sv
// Stream bundle for the SSS demapper: FFT bins in, hard-decision bit vector out.
interface sss_demapper_if #(
    parameter int IN_DW   = 32,
    parameter int SSS_LEN = 127
);
    logic [IN_DW-1:0]   s_axis_in_tdata;
    logic               s_axis_in_tvalid;
    logic [SSS_LEN-1:0] m_axis_out_tdata;
    logic               m_axis_out_tvalid;
    logic               m_axis_out_tready;

    modport master (
        output s_axis_in_tdata,
        output s_axis_in_tvalid,
        output m_axis_out_tready,
        input  m_axis_out_tdata,
        input  m_axis_out_tvalid
    );

    modport slave (
        input  s_axis_in_tdata,
        input  s_axis_in_tvalid,
        input  m_axis_out_tready,
        output m_axis_out_tdata,
        output m_axis_out_tvalid
    );
endinterface

// File: rtl/sss_demapper.sv
// Captures SSS_LEN FFT bins starting at SSS_START_BIN, slices the sign of the real
// part into a bit vector and accumulates |re|; result held until downstream accepts.
module sss_demapper #(
    parameter int IN_DW         = 32,
    parameter int SSS_LEN       = 127,
    parameter int SSS_START_BIN = 64,
    localparam int EN_DW        = IN_DW/2 + 7
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    sss_demapper_if.slave     axis,
    input  logic              SSS_valid_i,
    input  logic              SSS_start_i,
    output logic [EN_DW-1:0]  energy_o,
    output logic              sss_overflow_o
);
    localparam int HW    = IN_DW / 2;
    localparam int CNT_W = (SSS_START_BIN > 0) ? $clog2(SSS_START_BIN + 1) : 1;
    localparam int IDX_W = (SSS_LEN > 1) ? $clog2(SSS_LEN) : 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_SKIP    = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;
    localparam logic [1:0] S_HOLD    = 2'd3;

    // Magnitude of a signed real part; the most negative code clamps to max positive.
    function automatic logic [HW-2:0] abs_sat(input logic signed [HW-1:0] v);
        logic signed [HW-1:0] n;
        if (!v[HW-1]) return v[HW-2:0];
        if (v == {1'b1, {(HW-1){1'b0}}}) return '1;
        n = -v;
        return n[HW-2:0];
    endfunction

    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [SSS_LEN-1:0] bits_q, bits_d;
    logic [EN_DW-1:0]   energy_q, energy_d;
    logic               tvalid_q, tvalid_d;
    logic               ovf_q, ovf_d;

    logic                 accept, xfer, restart, capture;
    logic signed [HW-1:0] re;
    logic [IDX_W-1:0]     cap_idx;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        bits_d   = bits_q;
        energy_d = energy_q;
        tvalid_d = tvalid_q;
        ovf_d    = ovf_q;
        capture  = 1'b0;

        accept  = axis.s_axis_in_tvalid & SSS_valid_i;
        xfer    = tvalid_q & axis.m_axis_out_tready;
        re      = axis.s_axis_in_tdata[HW-1:0];
        restart = SSS_start_i && ((state_q != S_HOLD) || xfer);

        if (state_q == S_HOLD && xfer) begin
            state_d  = S_IDLE;
            tvalid_d = 1'b0;
        end
        if (state_q == S_HOLD && SSS_start_i && !xfer) ovf_d = 1'b1;

        if (restart) begin
            state_d  = S_SKIP;
            cnt_d    = '0;
            idx_d    = '0;
            bits_d   = '0;
            energy_d = '0;
        end

        // A beat arriving with the start pulse is evaluated against the restarted state.
        cap_idx = idx_d;
        if (accept) begin
            if (state_d == S_SKIP) begin
                if (cnt_d == CNT_W'(SSS_START_BIN)) begin
                    capture = 1'b1;
                    cap_idx = '0;
                end else begin
                    cnt_d = cnt_d + 1'b1;
                end
            end else if (state_d == S_CAPTURE) begin
                capture = 1'b1;
            end
        end

        if (capture) begin
            bits_d[cap_idx] = re[HW-1];
            energy_d        = energy_d + EN_DW'(abs_sat(re));
            idx_d           = cap_idx + 1'b1;
            if (cap_idx == IDX_W'(SSS_LEN - 1)) begin
                state_d  = S_HOLD;
                tvalid_d = 1'b1;
            end else begin
                state_d  = S_CAPTURE;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            bits_q   <= '0;
            energy_q <= '0;
            tvalid_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            bits_q   <= bits_d;
            energy_q <= energy_d;
            tvalid_q <= tvalid_d;
            ovf_q    <= ovf_d;
        end
    end

    assign axis.m_axis_out_tdata  = bits_q;
    assign axis.m_axis_out_tvalid = tvalid_q;
    assign energy_o               = energy_q;
    assign sss_overflow_o         = ovf_q;
endmodule

// File: tb/tb_sss_demapper.sv
// Directed bench for sss_demapper: table of full-symbol vectors plus restart/overflow/reset sequences.
module tb_sss_demapper;
    logic        clk = 1'b0;
    logic        reset_ni;
    logic        sss_valid, sss_start;
    logic [22:0] energy;
    logic        ovf;

    always #5 clk = ~clk;

    sss_demapper_if #(.IN_DW(32), .SSS_LEN(127)) bus ();

    sss_demapper #(.IN_DW(32), .SSS_LEN(127), .SSS_START_BIN(64)) dut (
        .clk_i         (clk),
        .reset_ni      (reset_ni),
        .axis          (bus),
        .SSS_valid_i   (sss_valid),
        .SSS_start_i   (sss_start),
        .energy_o      (energy),
        .sss_overflow_o(ovf)
    );

    typedef struct {
        logic signed [15:0] first;
        logic signed [15:0] mid;
        logic signed [15:0] last;
        bit                 gaps;
        bit                 hold;
        logic [126:0]       exp_data;
        logic [22:0]        exp_en;
    } vec_t;

    vec_t         vecs[6];
    int           n_chk, n_fail;
    int           pulses, rise_at, cur_bin, bad;
    bit           prev_tv;
    logic [126:0] cap_data;
    logic [22:0]  cap_en;
    logic [126:0] v0_data;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic sample();
        @(posedge clk);
        #1;
        if (bus.m_axis_out_tvalid && !prev_tv) begin
            pulses++;
            rise_at  = cur_bin;
            cap_data = bus.m_axis_out_tdata;
            cap_en   = energy;
        end
        prev_tv = bus.m_axis_out_tvalid;
    endtask

    task automatic drive_beat(input logic signed [15:0] r, input bit acc, input bit st);
        @(negedge clk);
        bus.s_axis_in_tdata = {16'h5A5A, r};
        if (acc) begin
            bus.s_axis_in_tvalid = 1'b1; sss_valid = 1'b1;
        end else if ($urandom_range(1) == 1) begin
            bus.s_axis_in_tvalid = 1'b0; sss_valid = 1'b1;
        end else begin
            bus.s_axis_in_tvalid = 1'b1; sss_valid = 1'b0;
        end
        sss_start = st;
        sample();
    endtask

    task automatic idle();
        @(negedge clk);
        bus.s_axis_in_tvalid = 1'b0;
        sss_valid            = 1'b0;
        sss_start            = 1'b0;
        sample();
    endtask

    // Bins 0..63 and 191..255 carry decoy values that would corrupt the result if captured.
    task automatic run_symbol(input logic signed [15:0] first, input logic signed [15:0] mid,
                              input logic signed [15:0] last, input bit gaps, input bit rdy);
        int b = 0;
        logic signed [15:0] r;
        pulses  = 0;
        rise_at = -1;
        bus.m_axis_out_tready = rdy;
        while (b < 256) begin
            if (gaps && $urandom_range(1) == 1) begin
                drive_beat(16'sh8000, 1'b0, 1'b0);
            end else begin
                if (b < 64)        r = -16'sd3;
                else if (b == 64)  r = first;
                else if (b < 190)  r = mid;
                else if (b == 190) r = last;
                else               r = -16'sd7;
                cur_bin = b;
                drive_beat(r, 1'b1, (b == 0));
                b++;
            end
        end
        if (rdy) repeat (3) idle();
    endtask

    initial begin
        n_chk = 0; n_fail = 0; pulses = 0; rise_at = -1; cur_bin = 0; prev_tv = 1'b0; bad = 0;
        reset_ni = 1'b0;
        sss_valid = 1'b0; sss_start = 1'b0;
        bus.s_axis_in_tdata = '0; bus.s_axis_in_tvalid = 1'b0; bus.m_axis_out_tready = 1'b0;
        v0_data = 127'h4000_0000_0000_0000_0000_0000_0000_0001;

        vecs[0] = '{-16'sd100, 16'sd100, -16'sd100, 1'b0, 1'b0, v0_data, 23'd12700};
        vecs[1] = '{-16'sd100, 16'sd100, -16'sd100, 1'b0, 1'b1, v0_data, 23'd12700};
        vecs[2] = '{-16'sd100, 16'sd100, -16'sd100, 1'b1, 1'b0, v0_data, 23'd12700};
        vecs[3] = '{16'sh8000, 16'sh8000, 16'sh8000, 1'b0, 1'b0, {127{1'b1}}, 23'd4161409};
        vecs[4] = '{16'sd0, 16'sd1, 16'sd32767, 1'b0, 1'b0, 127'd0, 23'd32892};
        vecs[5] = '{16'sd5, -16'sd1, -16'sd32767, 1'b0, 1'b0, {{126{1'b1}}, 1'b0}, 23'd32897};

        repeat (2) @(posedge clk);
        #1;
        chk("reset_tvalid", 128'(bus.m_axis_out_tvalid), 128'(0));
        chk("reset_tdata", 128'(bus.m_axis_out_tdata), 128'(0));
        chk("reset_energy", 128'(energy), 128'(0));
        chk("reset_ovf", 128'(ovf), 128'(0));
        @(negedge clk);
        reset_ni = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_symbol(vecs[i].first, vecs[i].mid, vecs[i].last, vecs[i].gaps, !vecs[i].hold);
            chk($sformatf("v%0d_pulses", i), 128'(pulses), 128'(1));
            chk($sformatf("v%0d_rise_bin", i), 128'(rise_at), 128'(190));
            chk($sformatf("v%0d_tdata", i), 128'(cap_data), 128'(vecs[i].exp_data));
            chk($sformatf("v%0d_energy", i), 128'(cap_en), 128'(vecs[i].exp_en));
            if (vecs[i].hold) begin
                bad = 0;
                for (int k = 0; k < 10; k++) begin
                    idle();
                    if (!(bus.m_axis_out_tvalid === 1'b1 && bus.m_axis_out_tdata === vecs[i].exp_data
                          && energy === vecs[i].exp_en)) bad++;
                end
                chk($sformatf("v%0d_hold_stable", i), 128'(bad), 128'(0));
                @(negedge clk);
                bus.m_axis_out_tready = 1'b1;
                sample();
                chk($sformatf("v%0d_drop_after_ready", i), 128'(bus.m_axis_out_tvalid), 128'(0));
                repeat (2) idle();
            end
            chk($sformatf("v%0d_ovf", i), 128'(ovf), 128'(0));
        end

        // Restart at bin 100 of a symbol already in capture.
        bus.m_axis_out_tready = 1'b1;
        drive_beat(-16'sd50, 1'b1, 1'b1);
        for (int k = 1; k < 100; k++) drive_beat(-16'sd50, 1'b1, 1'b0);
        chk("restart_no_early_out", 128'(bus.m_axis_out_tvalid), 128'(0));
        run_symbol(-16'sd100, 16'sd100, -16'sd100, 1'b0, 1'b1);
        chk("restart_pulses", 128'(pulses), 128'(1));
        chk("restart_tdata", 128'(cap_data), 128'(v0_data));
        chk("restart_energy", 128'(cap_en), 128'(23'd12700));
        chk("restart_ovf", 128'(ovf), 128'(0));

        // Start coinciding with the transfer cycle goes straight into a new capture.
        run_symbol(-16'sd100, 16'sd100, -16'sd100, 1'b0, 1'b0);
        chk("xfer_start_first_pulse", 128'(pulses), 128'(1));
        run_symbol(16'sd0, 16'sd1, 16'sd32767, 1'b0, 1'b1);
        chk("xfer_start_pulses", 128'(pulses), 128'(1));
        chk("xfer_start_rise_bin", 128'(rise_at), 128'(190));
        chk("xfer_start_tdata", 128'(cap_data), 128'(0));
        chk("xfer_start_energy", 128'(cap_en), 128'(23'd32892));
        chk("xfer_start_ovf", 128'(ovf), 128'(0));

        // Start while holding an unaccepted result is dropped and flagged.
        run_symbol(-16'sd100, 16'sd100, -16'sd100, 1'b0, 1'b0);
        drive_beat(16'sh8000, 1'b1, 1'b1);
        chk("ovf_set", 128'(ovf), 128'(1));
        for (int k = 0; k < 256; k++) drive_beat(16'sh8000, 1'b1, 1'b0);
        chk("ovf_hold_tvalid", 128'(bus.m_axis_out_tvalid), 128'(1));
        chk("ovf_hold_tdata", 128'(bus.m_axis_out_tdata), 128'(v0_data));
        chk("ovf_hold_energy", 128'(energy), 128'(23'd12700));
        pulses = 0;
        bus.m_axis_out_tready = 1'b1;
        idle();
        chk("ovf_drop_after_xfer", 128'(bus.m_axis_out_tvalid), 128'(0));
        repeat (5) idle();
        chk("ovf_no_second_out", 128'(pulses), 128'(0));
        chk("ovf_sticky", 128'(ovf), 128'(1));

        // Asynchronous reset in the middle of a capture.
        drive_beat(16'sh8000, 1'b1, 1'b1);
        for (int k = 1; k < 100; k++) drive_beat(16'sh8000, 1'b1, 1'b0);
        @(posedge clk);
        #3;
        reset_ni = 1'b0;
        #1;
        chk("areset_tvalid", 128'(bus.m_axis_out_tvalid), 128'(0));
        chk("areset_tdata", 128'(bus.m_axis_out_tdata), 128'(0));
        chk("areset_energy", 128'(energy), 128'(0));
        chk("areset_ovf", 128'(ovf), 128'(0));
        @(negedge clk);
        reset_ni = 1'b1;
        pulses = 0;
        for (int k = 0; k < 200; k++) drive_beat(16'sh8000, 1'b1, 1'b0);
        chk("areset_no_output", 128'(pulses), 128'(0));
        chk("areset_tvalid_low", 128'(bus.m_axis_out_tvalid), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/sss_demapper.md
SSS_DEMAPPER -- requirements
Module: sss_demapper

Interface
REQ-001 Parameter IN_DW, default 32: FFT sample width; real part in bits [IN_DW/2-1:0], imaginary part in bits [IN_DW-1:IN_DW/2], both signed two's complement.
REQ-002 Parameter SSS_LEN, default 127: number of SSS subcarriers captured.
REQ-003 Parameter SSS_START_BIN, default 64: index of the first SSS bin within the FFT output symbol.
REQ-004 Parameter EN_DW, fixed at IN_DW/2+7: energy output width.
REQ-005 clk_i  input  1  single clock; all logic on rising edge.
REQ-006 reset_ni  input  1  asynchronous, active-low reset.
REQ-007 s_axis_in_tdata  input  IN_DW  FFT bin from upstream FFT demodulator.
REQ-008 s_axis_in_tvalid  input  1  FFT bin valid.
REQ-009 SSS_valid_i  input  1  qualifies bins as belonging to the SSS symbol.
REQ-010 SSS_start_i  input  1  one-cycle pulse that arms capture of a new SSS symbol.
REQ-011 m_axis_out_tdata  output  SSS_LEN  hard-decision SSS bits; bit k corresponds to bin SSS_START_BIN+k.
REQ-012 m_axis_out_tvalid  output  1  output bit vector valid.
REQ-013 m_axis_out_tready  input  1  downstream ready.
REQ-014 energy_o  output  EN_DW  sum of |re| over the captured bins; valid with m_axis_out_tvalid.
REQ-015 sss_overflow_o  output  1  sticky flag: an SSS symbol was dropped.

Function
REQ-016 An accepted beat is any cycle with s_axis_in_tvalid=1 and SSS_valid_i=1; only accepted beats advance the bin counter.
REQ-017 The FSM has four states: IDLE, SKIP, CAPTURE and HOLD.
REQ-018 IDLE: when SSS_start_i=1, bin counter clears and the FSM enters SKIP; an accepted beat in the same cycle is bin 0.
REQ-019 SKIP: accepted beats increment the bin counter; when the bin index equals SSS_START_BIN, that beat is captured as bit 0 and the FSM enters CAPTURE (if SSS_START_BIN=0 the bin-0 beat is captured directly).
REQ-020 CAPTURE: each accepted beat stores bit k = sign bit of its real part (1 when re<0) and adds |re| to the energy accumulator.
REQ-021 |re| of the most negative value saturates to 2^(IN_DW/2-1)-1.
REQ-022 The energy accumulator is EN_DW bits wide and cannot overflow for SSS_LEN<=127.
REQ-023 After bit SSS_LEN-1 is captured, m_axis_out_tvalid rises on the next cycle and the FSM enters HOLD.
REQ-024 Accepted beats after the last captured bin are ignored.
REQ-025 HOLD: m_axis_out_tdata, energy_o and m_axis_out_tvalid are held stable until m_axis_out_tready=1.
REQ-026 On a transfer cycle (tvalid=1 and tready=1), m_axis_out_tvalid drops the next cycle and the FSM returns to IDLE.
REQ-027 If SSS_start_i=1 in the transfer cycle, the FSM goes directly to SKIP with the counter cleared.
REQ-028 SSS_start_i in SKIP or CAPTURE restarts capture: counter, bit register and accumulator clear, and an accepted beat in that cycle is bin 0.
REQ-029 SSS_start_i in HOLD without a transfer is dropped and sets sss_overflow_o; the flag stays set until reset.
REQ-030 Gaps (s_axis_in_tvalid=0 or SSS_valid_i=0) in any state stall the counter without aborting.

Reset
REQ-031 On reset_ni=0 (asynchronous): FSM=IDLE, counter=0, m_axis_out_tvalid=0, m_axis_out_tdata=0, energy_o=0, sss_overflow_o=0.
REQ-032 Reset asserted mid-capture or in HOLD discards the partial or pending result; no output appears after release until a new SSS_start_i.

Verification
REQ-033 Pulse SSS_start_i, then 256 contiguous accepted beats with re=+100 for bins 64..190 (bins 64 and 190 re=-100), tready=1 -> one tvalid pulse, tdata bit0=1, bit126=1, other bits 0, energy_o=12700, tvalid high one cycle after bin 190.
REQ-034 Same stimulus with tready=0 for 10 cycles after tvalid -> tdata, energy_o and tvalid stable for all 10 cycles; tvalid drops the cycle after tready=1.
REQ-035 Random s_axis_in_tvalid/SSS_valid_i gaps (50% duty) with known bins -> result identical to the gap-free run.
REQ-036 SSS_start_i re-pulsed at bin 100, followed by a full symbol -> output reflects only the second symbol; no overflow.
REQ-037 Second SSS_start_i while in HOLD with tready=0 -> sss_overflow_o=1 and stays 1; first result unchanged; no second output.
REQ-038 re=-2^15 on all captured bins -> all bits 1, energy_o=127*32767=4161409; reset_ni pulsed during CAPTURE -> all outputs 0 immediately and no output afterward.
